// File: rtl/fu_result_buffer_if.sv
// Handshake bundle between an FU writeback port, its result buffer and the CDB arbiter.
// The master side is the FU/CDB environment; the slave side is fu_result_buffer.
interface fu_result_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
);
    logic                       fu_valid;
    logic [TAG_W-1:0]           fu_tag;
    logic [DATA_W-1:0]          fu_v;
    logic                       fu_ready;
    logic                       ack;
    logic                       flush;
    logic                       done;
    logic [TAG_W-1:0]           rob_tag;
    logic [DATA_W-1:0]          v;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output fu_valid, fu_tag, fu_v, ack, flush,
        input  fu_ready, done, rob_tag, v, count
    );

    modport slave (
        input  fu_valid, fu_tag, fu_v, ack, flush,
        output fu_ready, done, rob_tag, v, count
    );
endinterface

// File: rtl/fu_result_buffer.sv
// Per-FU completion FIFO holding {rob_tag, v} until the CDB grants it.
// Optional same-cycle bypass of an empty buffer is enabled by defining FU_RESULT_BYPASS_EN.
module fu_result_buffer #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input logic                clock,
    input logic                reset,
    fu_result_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic [DATA_W-1:0] val_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  occ;
    logic              not_empty;
    logic              ready;
    logic              push;
    logic              pop;
    logic              write;

    assign not_empty    = (occ != '0);
    assign ready        = (occ != FULL_CNT);
    assign bus.fu_ready = ready;
    assign bus.count    = occ;
    assign push         = bus.fu_valid & ready;
    assign pop          = bus.ack & not_empty;

`ifdef FU_RESULT_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = push & ~not_empty;
    // A bypassed result granted in the same cycle is already on the CDB, so it is never stored.
    assign write      = push & ~(bypass_hit & bus.ack);
`else
    assign write      = push;
`endif

    always_comb begin
        bus.done    = 1'b0;
        bus.rob_tag = '0;
        bus.v       = '0;
        if (not_empty) begin
            bus.done    = 1'b1;
            bus.rob_tag = tag_mem[head];
            bus.v       = val_mem[head];
        end
`ifdef FU_RESULT_BYPASS_EN
        else if (bypass_hit) begin
            bus.done    = 1'b1;
            bus.rob_tag = bus.fu_tag;
            bus.v       = bus.fu_v;
        end
`endif
    end

    // Flush shares the reset path; a granted head in a flush cycle is simply discarded.
    always_ff @(posedge clock) begin
        if (!reset || bus.flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (write) tail <= tail + PTR_W'(1);
            if (pop)   head <= head + PTR_W'(1);
            case ({write, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !bus.flush && write) begin
            tag_mem[tail] <= bus.fu_tag;
            val_mem[tail] <= bus.fu_v;
        end
    end
endmodule

// File: tb/tb_fu_result_buffer.sv
// Randomized and directed bench for fu_result_buffer against a queue-based reference model.
// Honours FU_RESULT_BYPASS_EN so the same bench covers both builds.
module tb_fu_result_buffer;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
`ifdef FU_RESULT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clock;
    logic reset;
    int   total;
    int   bad;
    bit   model_live;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } entry_t;
    entry_t mq[$];

    fu_result_buffer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    fu_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic applyStimulus(input bit rst_n, input bit valid, input logic [TAG_W-1:0] tag,
                                 input logic [DATA_W-1:0] val, input bit ack, input bit flush);
        int      sz;
        bit      exp_ready;
        bit      exp_done;
        entry_t  e;
        logic [TAG_W-1:0]  exp_tag;
        logic [DATA_W-1:0] exp_v;
        @(negedge clock);
        reset        = rst_n;
        bus.fu_valid = valid;
        bus.fu_tag   = tag;
        bus.fu_v     = val;
        bus.ack      = ack;
        bus.flush    = flush;
        #1;
        sz        = mq.size();
        exp_ready = (sz < DEPTH);
        exp_done  = 1'b0;
        exp_tag   = '0;
        exp_v     = '0;
        if (sz > 0) begin
            exp_done = 1'b1;
            exp_tag  = mq[0].tag;
            exp_v    = mq[0].val;
        end else if (BYPASS && valid) begin
            exp_done = 1'b1;
            exp_tag  = tag;
            exp_v    = val;
        end
        if (model_live) begin
            checkOutput("fu_ready", 64'(bus.fu_ready), 64'(exp_ready));
            checkOutput("count",    64'(bus.count),    64'(sz));
            checkOutput("done",     64'(bus.done),     64'(exp_done));
            checkOutput("rob_tag",  64'(bus.rob_tag),  64'(exp_tag));
            checkOutput("v",        64'(bus.v),        64'(exp_v));
        end
        @(posedge clock);
        if (!rst_n || flush) begin
            mq.delete();
            if (!rst_n) model_live = 1'b1;
        end else begin
            if (BYPASS && sz == 0 && valid && ack) begin
                // consumed straight onto the CDB
            end else begin
                if (ack && sz > 0) void'(mq.pop_front());
                if (valid && exp_ready) begin
                    e.tag = tag;
                    e.val = val;
                    mq.push_back(e);
                end
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        model_live = 1'b0;
        reset = 1'b0;
        bus.fu_valid = 1'b0; bus.fu_tag = '0; bus.fu_v = '0; bus.ack = 1'b0; bus.flush = 1'b0;

        $display("[TB] reset with fu_valid held");
        applyStimulus(0, 1, 5'd9, 32'h1111_1111, 0, 0);
        applyStimulus(0, 1, 5'd9, 32'h1111_1111, 0, 0);
        applyStimulus(1, 0, '0, '0, 0, 0);

        $display("[TB] single pass");
        applyStimulus(1, 1, 5'd3, 32'hDEAD, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, '0, 0, 0);
        applyStimulus(1, 0, '0, '0, 1, 0);
        applyStimulus(1, 0, '0, '0, 0, 0);

        $display("[TB] fill and backpressure");
        for (int t = 1; t <= 5; t++) applyStimulus(1, 1, 5'(t), 32'(t * 16'h0101), 0, 0);
        applyStimulus(1, 1, 5'd5, 32'h0505, 1, 0);
        applyStimulus(1, 1, 5'd5, 32'h0505, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, '0, '0, 1, 0);

        $display("[TB] wrap with simultaneous push and pop");
        applyStimulus(1, 1, 5'd31, 32'hFFFF_0000, 0, 0);
        for (int t = 0; t < 10; t++) applyStimulus(1, 1, 5'(t), 32'hA000 + 32'(t), 1, 0);
        applyStimulus(1, 0, '0, '0, 1, 0);
        applyStimulus(1, 0, '0, '0, 0, 0);

        $display("[TB] flush");
        for (int t = 0; t < 3; t++) applyStimulus(1, 1, 5'(20 + t), 32'hB000 + 32'(t), 0, 0);
        applyStimulus(1, 1, 5'd30, 32'hCCCC, 1, 1);
        applyStimulus(1, 1, 5'd12, 32'h1234_5678, 0, 0);
        applyStimulus(1, 0, '0, '0, 1, 0);
        applyStimulus(1, 0, '0, '0, 0, 0);

        $display("[TB] empty push with same-cycle grant");
        applyStimulus(1, 1, 5'd7, 32'h7777, 1, 0);
        applyStimulus(1, 0, '0, '0, 0, 0);
        applyStimulus(1, 0, '0, '0, 1, 0);
        applyStimulus(1, 0, '0, '0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 9) < 6),
                          5'($urandom()),
                          $urandom(),
                          ($urandom_range(0, 9) < (i < 300 ? 3 : 6)),
                          ($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
